// File: rtl/gcd_datapath.sv
// Datapath for the subtractive GCD engine: X/Y operand registers, result G, status flags and an iteration counter.
// Define GCD_DP_ERRCHK_EN to add a sticky err output that flags illegal subtract commands.
module gcd_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] xin,
    input  logic [WIDTH-1:0] yin,
    input  logic             xmsel,
    input  logic             ymsel,
    input  logic             xld,
    input  logic             yld,
    input  logic             gld,
    output logic             eqflg,
    output logic             ltflg,
    output logic             zflg,
    output logic [WIDTH-1:0] gcd,
    output logic             gvalid,
`ifdef GCD_DP_ERRCHK_EN
    output logic             err,
`endif
    output logic [CNT_W-1:0] iter_cnt
);

    logic [WIDTH-1:0] x_p0, y_p0, g_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             vld_p0;

    logic             x_sub, y_sub, op_load, sub_upd;
    logic [WIDTH-1:0] x_next, y_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        return v + 1'b1;
    endfunction

    always_comb begin
        x_sub   = xld & ~xmsel;
        y_sub   = yld & ~ymsel;
        op_load = (xld & xmsel) | (yld & ymsel);
        sub_upd = x_sub | y_sub;
        x_next  = xmsel ? xin : (x_p0 - y_p0);
        y_next  = ymsel ? yin : (y_p0 - x_p0);
        eqflg   = (x_p0 == y_p0);
        ltflg   = (x_p0 < y_p0);
        zflg    = (x_p0 == '0) | (y_p0 == '0);
    end

    // Operand and result registers; subtractions see pre-edge values of both operands
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            x_p0 <= '0;
            y_p0 <= '0;
            g_p0 <= '0;
        end else begin
            if (xld) x_p0 <= x_next;
            if (yld) y_p0 <= y_next;
            if (gld) g_p0 <= x_p0;
        end
    end

    // Status: operand load takes priority over both gld and subtract counting
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            vld_p0 <= 1'b0;
            cnt_p0 <= '0;
        end else begin
            if (op_load)
                vld_p0 <= 1'b0;
            else if (gld)
                vld_p0 <= 1'b1;

            if (op_load)
                cnt_p0 <= '0;
            else if (sub_upd)
                cnt_p0 <= sat_inc(cnt_p0);
        end
    end

`ifdef GCD_DP_ERRCHK_EN
    logic err_p0;
    logic err_hit;

    always_comb begin
        err_hit = (sub_upd & zflg)
                | (x_sub & y_sub)
                | (x_sub & ltflg)
                | (y_sub & ~ltflg & ~eqflg);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            err_p0 <= 1'b0;
        else if (op_load)
            err_p0 <= 1'b0;
        else if (err_hit)
            err_p0 <= 1'b1;
    end

    assign err = err_p0;
`endif

    assign gcd      = g_p0;
    assign gvalid   = vld_p0;
    assign iter_cnt = cnt_p0;

endmodule

// File: tb/tb_gcd_datapath.sv
// Directed-vector bench for gcd_datapath; a second instance with CNT_W=2 covers counter saturation.
module tb_gcd_datapath;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] xin, yin;
    logic       xmsel, ymsel, xld, yld, gld;

    logic       eqflg, ltflg, zflg, gvalid;
    logic [7:0] gcd, iter_cnt;
    logic       eqflg_s, ltflg_s, zflg_s, gvalid_s;
    logic [7:0] gcd_s;
    logic [1:0] iter_cnt_s;
`ifdef GCD_DP_ERRCHK_EN
    logic       err, err_s;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    gcd_datapath #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .clr_n(clr_n), .xin(xin), .yin(yin),
        .xmsel(xmsel), .ymsel(ymsel), .xld(xld), .yld(yld), .gld(gld),
        .eqflg(eqflg), .ltflg(ltflg), .zflg(zflg), .gcd(gcd), .gvalid(gvalid),
`ifdef GCD_DP_ERRCHK_EN
        .err(err),
`endif
        .iter_cnt(iter_cnt)
    );

    gcd_datapath #(.WIDTH(8), .CNT_W(2)) dut_s (
        .clk(clk), .clr_n(clr_n), .xin(xin), .yin(yin),
        .xmsel(xmsel), .ymsel(ymsel), .xld(xld), .yld(yld), .gld(gld),
        .eqflg(eqflg_s), .ltflg(ltflg_s), .zflg(zflg_s), .gcd(gcd_s), .gvalid(gvalid_s),
`ifdef GCD_DP_ERRCHK_EN
        .err(err_s),
`endif
        .iter_cnt(iter_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic xl, input logic xs, input logic yl, input logic ys,
                         input logic gl, input logic [7:0] xv, input logic [7:0] yv);
        xld = xl; xmsel = xs; yld = yl; ymsel = ys; gld = gl; xin = xv; yin = yv;
        step();
        xld = 1'b0; yld = 1'b0; gld = 1'b0;
    endtask

    initial begin
        clr_n = 1'b0;
        // Reset held with random commands on the inputs
        for (int i = 0; i < 4; i++) begin
            xin = 8'($urandom); yin = 8'($urandom);
            xmsel = 1'($urandom); ymsel = 1'($urandom);
            xld = 1'($urandom); yld = 1'($urandom); gld = 1'($urandom);
            step();
        end
        chk("rst_gcd", gcd, 0);
        chk("rst_gvalid", gvalid, 0);
        chk("rst_iter", iter_cnt, 0);
        chk("rst_eq", eqflg, 1);
        chk("rst_lt", ltflg, 0);
        chk("rst_z", zflg, 1);

        xld = 0; yld = 0; gld = 0; xmsel = 0; ymsel = 0;
        clr_n = 1'b1;
        step();
        step();
        chk("rel_gcd", gcd, 0);
        chk("rel_iter", iter_cnt, 0);
        chk("rel_eq", eqflg, 1);
        chk("rel_z", zflg, 1);

        // GCD(36,24)
        drive(1, 1, 1, 1, 0, 8'd36, 8'd24);
        chk("ld36_eq", eqflg, 0);
        chk("ld36_lt", ltflg, 0);
        chk("ld36_z", zflg, 0);
        chk("ld36_iter", iter_cnt, 0);
        drive(1, 0, 0, 0, 0, 8'd0, 8'd0);        // X = 12
        chk("s1_lt", ltflg, 1);
        chk("s1_iter", iter_cnt, 1);
        drive(0, 0, 1, 0, 0, 8'd0, 8'd0);        // Y = 12
        chk("s2_eq", eqflg, 1);
        chk("s2_iter", iter_cnt, 2);
        chk("s2_gvalid", gvalid, 0);
        drive(0, 0, 0, 0, 1, 8'd0, 8'd0);
        chk("g12_gcd", gcd, 12);
        chk("g12_gvalid", gvalid, 1);
        step();
        chk("g12_hold", gcd, 12);
        chk("g12_hold_vld", gvalid, 1);

        // Reload while valid
        drive(1, 1, 1, 1, 0, 8'd7, 8'd7);
        chk("ld7_gvalid", gvalid, 0);
        chk("ld7_iter", iter_cnt, 0);
        chk("ld7_eq", eqflg, 1);
        chk("ld7_gcd_kept", gcd, 12);
        drive(0, 0, 0, 0, 1, 8'd0, 8'd0);
        chk("g7_gcd", gcd, 7);
        chk("g7_gvalid", gvalid, 1);

        // Operand load and gld together: G takes old X, gvalid cleared
        drive(1, 1, 1, 1, 0, 8'd9, 8'd3);
        drive(0, 0, 0, 0, 1, 8'd0, 8'd0);
        chk("g9_vld", gvalid, 1);
        drive(1, 1, 1, 1, 1, 8'd4, 8'd4);
        chk("ldg_gcd", gcd, 9);
        chk("ldg_gvalid", gvalid, 0);
        chk("ldg_eq", eqflg, 1);

        // Flags: 5 vs 9, then Y <= 4
        drive(1, 1, 1, 1, 0, 8'd5, 8'd9);
        chk("f59_lt", ltflg, 1);
        chk("f59_eq", eqflg, 0);
        drive(0, 0, 1, 0, 0, 8'd0, 8'd0);
        chk("f54_lt", ltflg, 0);
        chk("f54_eq", eqflg, 0);
        chk("f54_iter", iter_cnt, 1);
        drive(1, 1, 0, 0, 0, 8'd4, 8'd0);        // X <= 4 confirms Y == 4
        chk("f54_yval", eqflg, 1);

        // Simultaneous update and saturation: X=10,Y=3 -> X=7,Y=249
        drive(1, 1, 1, 1, 0, 8'd10, 8'd3);
        drive(1, 0, 1, 0, 0, 8'd0, 8'd0);
        chk("sim_lt", ltflg_s, 1);
        chk("sim_iter_s", iter_cnt_s, 1);
        chk("sim_iter", iter_cnt, 1);
        for (int i = 0; i < 4; i++)
            drive(0, 0, 1, 0, 0, 8'd0, 8'd0);    // Y: 242, 235, 228, 221
        chk("sat_iter_s", iter_cnt_s, 3);
        chk("sat_iter", iter_cnt, 5);
        drive(1, 1, 0, 0, 0, 8'd221, 8'd0);
        chk("sat_yval", eqflg_s, 1);

        // Mixed cycle: X loads, Y subtracts old X; counter cleared
        drive(1, 1, 1, 1, 0, 8'd3, 8'd10);
        drive(0, 0, 1, 0, 0, 8'd0, 8'd0);        // Y = 7, iter 1
        drive(1, 1, 1, 0, 0, 8'd20, 8'd0);       // X = 20, Y = 7 - 3 = 4
        chk("mix_iter", iter_cnt, 0);
        drive(1, 1, 0, 0, 0, 8'd4, 8'd0);
        chk("mix_yval", eqflg, 1);

        // Zero operand
        drive(1, 1, 1, 1, 0, 8'd0, 8'd5);
        chk("z_flag", zflg, 1);
`ifdef GCD_DP_ERRCHK_EN
        chk("z_err_pre", err, 0);
`endif
        drive(0, 0, 1, 0, 0, 8'd0, 8'd0);
        chk("z_lt", ltflg, 1);
        chk("z_iter", iter_cnt, 1);
`ifdef GCD_DP_ERRCHK_EN
        chk("z_err", err, 1);
`endif
        drive(1, 1, 0, 0, 0, 8'd5, 8'd0);
        chk("z_yval", eqflg, 1);
        drive(1, 1, 1, 1, 0, 8'd4, 8'd2);
`ifdef GCD_DP_ERRCHK_EN
        chk("z_err_clr", err, 0);
        drive(1, 0, 0, 0, 0, 8'd0, 8'd0);        // X=2, Y=2 legal
        chk("e_legal", err, 0);
        drive(1, 0, 1, 0, 0, 8'd0, 8'd0);        // both subtract: X=0, Y=0
        chk("e_both", err, 1);
        drive(1, 1, 1, 1, 0, 8'd3, 8'd8);
        chk("e_clr2", err, 0);
        drive(1, 0, 0, 0, 0, 8'd0, 8'd0);        // X < Y underflow
        chk("e_under", err, 1);
        drive(1, 1, 1, 1, 0, 8'd4, 8'd2);
`endif

        // Reset mid-computation, between edges
        drive(1, 0, 0, 0, 0, 8'd0, 8'd0);        // X = 2
        drive(0, 0, 0, 0, 1, 8'd0, 8'd0);
        chk("pre_rst_gcd", gcd, 2);
        chk("pre_rst_vld", gvalid, 1);
        chk("pre_rst_iter", iter_cnt, 1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst_gcd", gcd, 0);
        chk("arst_vld", gvalid, 0);
        chk("arst_iter", iter_cnt, 0);
        chk("arst_eq", eqflg, 1);
        chk("arst_z", zflg, 1);
`ifdef GCD_DP_ERRCHK_EN
        chk("arst_err", err, 0);
`endif
        step();
        clr_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
